// File: rtl/forward_source_tracker.sv
`default_nettype none
// ============================================================================
// Module      : forward_source_tracker
// Description : Tracks the destination register of each instruction that has
//               left decode, one slot per post-decode stage, captures stage
//               results as they appear, and produces per-stage forwarding
//               selects, forwarding values and a hazard flag for the operand
//               fields of the queue-head instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module forward_source_tracker #(
    parameter int POST_DEC_LD = 3,
    parameter int REG_W       = 5,
    parameter int VAL_W       = 64,
    parameter int RIP_IDX     = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         issue_valid,
    input  logic                         issue_wr,
    input  logic [REG_W-1:0]             issue_dst,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         head_valid,
    input  logic [REG_W-1:0]             head_d,
    input  logic [REG_W-1:0]             head_s,
    input  logic [REG_W-1:0]             head_t,
    input  logic [POST_DEC_LD-1:0]       res_valid,
    input  logic [POST_DEC_LD*VAL_W-1:0] res_val,
    output logic [POST_DEC_LD*3-1:0]     fwd_sig_from,
    output logic [POST_DEC_LD*VAL_W-1:0] fwd_val_from,
    output logic                         hazard
);

    // Operand lanes; lane numbering matches the {d,s,t} bit order of each
    // 3-bit select group (d is the MSB of the group).
    localparam int              C_OP_T   = 0;
    localparam int              C_OP_S   = 1;
    localparam int              C_OP_D   = 2;
    localparam int              C_NUM_OP = 3;
    localparam logic [REG_W-1:0] C_RIP   = REG_W'(RIP_IDX);

    // ------------------------------------------------------------------------
    // Slot state
    // ------------------------------------------------------------------------
    logic [POST_DEC_LD-1:0]            live_q, live_d;
    logic [POST_DEC_LD-1:0]            have_q, have_d;
    logic [POST_DEC_LD-1:0][REG_W-1:0] dst_q, dst_d;
    logic [POST_DEC_LD-1:0][VAL_W-1:0] val_q, val_d;

    // Per-slot combinational views
    logic [POST_DEC_LD-1:0]            w_avail;
    logic [POST_DEC_LD-1:0][VAL_W-1:0] w_cur;
    logic [C_NUM_OP-1:0][REG_W-1:0]    w_head;
    logic [C_NUM_OP-1:0][POST_DEC_LD-1:0] w_match;
    logic [C_NUM_OP-1:0][POST_DEC_LD-1:0] w_sel;
    logic                              w_hazard;

    assign w_head[C_OP_D] = head_d;
    assign w_head[C_OP_S] = head_s;
    assign w_head[C_OP_T] = head_t;

    // ------------------------------------------------------------------------
    // Per-slot availability, current value and raw operand matches.
    // A value is available either from the slot's captured copy or from the
    // stage producing it this very cycle (zero-cycle forwarding).
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < POST_DEC_LD; gi++) begin : g_slot
            assign w_avail[gi] = have_q[gi] | res_valid[gi];
            assign w_cur[gi]   = have_q[gi] ? val_q[gi]
                                            : res_val[gi*VAL_W +: VAL_W];

            for (genvar go = 0; go < C_NUM_OP; go++) begin : g_op
                // RIP is never tracked as a forwarding source.
                assign w_match[go][gi] = live_q[gi]
                                       & (dst_q[gi] == w_head[go])
                                       & (w_head[go] != C_RIP)
                                       & head_valid;
            end
        end
    endgenerate

    // Youngest-match selection per operand and hazard detection on the
    // selected slot only; older matches never override a younger one.
    always_comb begin
        w_sel    = '0;
        w_hazard = 1'b0;
        for (int op = 0; op < C_NUM_OP; op++) begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < POST_DEC_LD; i++) begin
                if (w_match[op][i] && !seen) begin
                    w_sel[op][i] = 1'b1;
                    if (!w_avail[i]) begin
                        w_hazard = 1'b1;
                    end
                end
                seen = seen | w_match[op][i];
            end
        end
    end

    // Drive outputs; everything is forced low while reset is asserted so the
    // decode stage sees no forwarding during and immediately after reset.
    always_comb begin
        fwd_sig_from = '0;
        fwd_val_from = '0;
        hazard       = w_hazard & rstn;
        for (int i = 0; i < POST_DEC_LD; i++) begin
            fwd_sig_from[i*3 +: 3] = {w_sel[C_OP_D][i], w_sel[C_OP_S][i],
                                      w_sel[C_OP_T][i]} & {3{rstn}};
            if (rstn && (w_sel[C_OP_D][i] || w_sel[C_OP_S][i] ||
                         w_sel[C_OP_T][i])) begin
                fwd_val_from[i*VAL_W +: VAL_W] = w_cur[i];
            end
        end
    end

    // Next slot state: shift one stage older each cycle, capturing a result
    // produced by a live slot as it moves; slot 0 takes the new issue.
    always_comb begin
        live_d = '0;
        have_d = '0;
        dst_d  = dst_q;
        val_d  = val_q;
        for (int i = 1; i < POST_DEC_LD; i++) begin
            live_d[i] = live_q[i-1];
            dst_d[i]  = dst_q[i-1];
            if (res_valid[i-1] && live_q[i-1]) begin
                have_d[i] = 1'b1;
                val_d[i]  = res_val[(i-1)*VAL_W +: VAL_W];
            end else begin
                have_d[i] = have_q[i-1];
                val_d[i]  = val_q[i-1];
            end
        end
        // A stalled decode injects a bubble into slot 0.
        live_d[0] = issue_valid & issue_wr & ~stall;
        dst_d[0]  = issue_dst;
        have_d[0] = 1'b0;
        val_d[0]  = '0;
        // Flush wins over any issue or captured result.
        if (flush) begin
            live_d = '0;
            have_d = '0;
        end
    end

    // Slot state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            live_q <= '0;
            have_q <= '0;
            dst_q  <= '0;
            val_q  <= '0;
        end else begin
            live_q <= live_d;
            have_q <= have_d;
            dst_q  <= dst_d;
            val_q  <= val_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_forward_source_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_source_tracker
// Description : Directed self-checking bench for forward_source_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_source_tracker;

    localparam int N  = 3;
    localparam int RW = 5;
    localparam int VW = 64;

    logic            clk;
    logic            rstn;
    logic            issue_valid;
    logic            issue_wr;
    logic [RW-1:0]   issue_dst;
    logic            stall;
    logic            flush;
    logic            head_valid;
    logic [RW-1:0]   head_d;
    logic [RW-1:0]   head_s;
    logic [RW-1:0]   head_t;
    logic [N-1:0]    res_valid;
    logic [N*VW-1:0] res_val;
    logic [N*3-1:0]  fwd_sig_from;
    logic [N*VW-1:0] fwd_val_from;
    logic            hazard;

    int n_checks;
    int n_pass;

    forward_source_tracker #(
        .POST_DEC_LD(N),
        .REG_W      (RW),
        .VAL_W      (VW),
        .RIP_IDX    (16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_dst   (issue_dst),
        .stall       (stall),
        .flush       (flush),
        .head_valid  (head_valid),
        .head_d      (head_d),
        .head_s      (head_s),
        .head_t      (head_t),
        .res_valid   (res_valid),
        .res_val     (res_val),
        .fwd_sig_from(fwd_sig_from),
        .fwd_val_from(fwd_val_from),
        .hazard      (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        issue_wr    = 1'b0;
        issue_dst   = '0;
        stall       = 1'b0;
        flush       = 1'b0;
        head_valid  = 1'b0;
        head_d      = '0;
        head_s      = '0;
        head_t      = '0;
        res_valid   = '0;
        res_val     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic issue(input logic [RW-1:0] dst);
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_dst   = dst;
        tick();
        issue_valid = 1'b0;
        issue_wr    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn        = 1'b0;
        head_valid  = 1'b1;
        res_valid   = 3'b111;
        res_val     = {N*VW{1'b1}};
        tick();
        #1;
        n_checks++;
        if (fwd_sig_from !== 9'b0 || fwd_val_from !== '0 || hazard !== 1'b0) begin
            $display("FAIL reset_outputs sig=%b hazard=%b val_nonzero=%b (want 0/0/0)",
                     fwd_sig_from, hazard, |fwd_val_from);
        end else n_pass++;
        do_reset();
    endtask

    task automatic test_single_issue();
        do_reset();
        issue(5'd3);
        head_valid = 1'b1;
        head_s     = 5'd3;
        res_valid  = 3'b001;
        res_val[0 +: VW] = 64'h55;
        #1;
        n_checks++;
        if (fwd_sig_from !== 9'b000_000_010) begin
            $display("FAIL single_sig got=%b want=000000010", fwd_sig_from);
        end else n_pass++;
        n_checks++;
        if (fwd_val_from[0 +: VW] !== 64'h55) begin
            $display("FAIL single_val got=%h want=55", fwd_val_from[0 +: VW]);
        end else n_pass++;
        n_checks++;
        if (hazard !== 1'b0) begin
            $display("FAIL single_hazard got=%b want=0", hazard);
        end else n_pass++;
    endtask

    task automatic test_unready();
        do_reset();
        issue(5'd3);
        head_valid = 1'b1;
        head_s     = 5'd3;
        #1;
        n_checks++;
        if (hazard !== 1'b1 || fwd_sig_from !== 9'b000_000_010) begin
            $display("FAIL unready_hazard got haz=%b sig=%b want haz=1 sig=000000010",
                     hazard, fwd_sig_from);
        end else n_pass++;
        tick();
        res_valid = 3'b010;
        res_val[VW +: VW] = 64'h77;
        #1;
        n_checks++;
        if (fwd_sig_from !== 9'b000_010_000 || hazard !== 1'b0) begin
            $display("FAIL unready_stage1 got sig=%b haz=%b want sig=000010000 haz=0",
                     fwd_sig_from, hazard);
        end else n_pass++;
        n_checks++;
        if (fwd_val_from[VW +: VW] !== 64'h77 || fwd_val_from[0 +: VW] !== 64'h0) begin
            $display("FAIL unready_val got v1=%h v0=%h want v1=77 v0=0",
                     fwd_val_from[VW +: VW], fwd_val_from[0 +: VW]);
        end else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        issue(5'd5);
        // Older instruction's result appears while it sits in slot 0.
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_dst   = 5'd5;
        res_valid   = 3'b001;
        res_val[0 +: VW] = 64'hA;
        tick();
        issue_valid = 1'b0;
        issue_wr    = 1'b0;
        res_val[0 +: VW] = 64'hB;
        head_valid  = 1'b1;
        head_d      = 5'd5;
        head_t      = 5'd5;
        #1;
        n_checks++;
        if (fwd_sig_from !== 9'b000_000_101) begin
            $display("FAIL priority_sig got=%b want=000000101", fwd_sig_from);
        end else n_pass++;
        n_checks++;
        if (fwd_val_from[0 +: VW] !== 64'hB || fwd_val_from[VW +: VW] !== 64'h0) begin
            $display("FAIL priority_val got v0=%h v1=%h want v0=b v1=0",
                     fwd_val_from[0 +: VW], fwd_val_from[VW +: VW]);
        end else n_pass++;
        // Younger unready match raises a hazard even though the older is ready.
        res_valid = 3'b000;
        #1;
        n_checks++;
        if (hazard !== 1'b1 || fwd_sig_from !== 9'b000_000_101) begin
            $display("FAIL priority_hazard got haz=%b sig=%b want haz=1 sig=000000101",
                     hazard, fwd_sig_from);
        end else n_pass++;
    endtask

    task automatic test_rip_nonwriter();
        do_reset();
        issue(5'd16);
        head_valid = 1'b1;
        head_d     = 5'd16;
        #1;
        n_checks++;
        if (fwd_sig_from !== 9'b0 || hazard !== 1'b0) begin
            $display("FAIL rip_nomatch got sig=%b haz=%b want 0/0", fwd_sig_from, hazard);
        end else n_pass++;
        issue_valid = 1'b1;
        issue_wr    = 1'b0;
        issue_dst   = 5'd2;
        tick();
        issue_valid = 1'b0;
        head_d      = 5'd0;
        head_s      = 5'd2;
        #1;
        n_checks++;
        if (fwd_sig_from !== 9'b0 || hazard !== 1'b0) begin
            $display("FAIL nonwriter_nomatch got sig=%b haz=%b want 0/0", fwd_sig_from, hazard);
        end else n_pass++;
    endtask

    task automatic test_stall_flush();
        do_reset();
        stall       = 1'b1;
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_dst   = 5'd7;
        tick();
        stall       = 1'b0;
        issue_valid = 1'b0;
        head_valid  = 1'b1;
        head_s      = 5'd7;
        #1;
        n_checks++;
        if (fwd_sig_from !== 9'b0 || hazard !== 1'b0) begin
            $display("FAIL stall_bubble got sig=%b haz=%b want 0/0", fwd_sig_from, hazard);
        end else n_pass++;
        issue(5'd1);
        issue(5'd2);
        issue(5'd3);
        head_d = 5'd1;
        head_s = 5'd2;
        head_t = 5'd3;
        #1;
        n_checks++;
        if (fwd_sig_from !== 9'b100_010_001 || hazard !== 1'b1) begin
            $display("FAIL three_live got sig=%b haz=%b want 100010001/1", fwd_sig_from, hazard);
        end else n_pass++;
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_dst   = 5'd4;
        tick();
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_wr    = 1'b0;
        head_s      = 5'd4;
        #1;
        n_checks++;
        if (fwd_sig_from !== 9'b0 || hazard !== 1'b0) begin
            $display("FAIL flush_clear got sig=%b haz=%b want 0/0", fwd_sig_from, hazard);
        end else n_pass++;
    endtask

    task automatic test_retire();
        do_reset();
        issue(5'd6);
        tick();
        tick();
        head_valid = 1'b1;
        head_d     = 5'd6;
        res_valid  = 3'b100;
        res_val[2*VW +: VW] = 64'h99;
        #1;
        n_checks++;
        if (fwd_sig_from !== 9'b100_000_000 || fwd_val_from[2*VW +: VW] !== 64'h99
            || hazard !== 1'b0) begin
            $display("FAIL last_stage got sig=%b v2=%h haz=%b want 100000000/99/0",
                     fwd_sig_from, fwd_val_from[2*VW +: VW], hazard);
        end else n_pass++;
        tick();
        #1;
        n_checks++;
        if (fwd_sig_from !== 9'b0 || hazard !== 1'b0) begin
            $display("FAIL retired got sig=%b haz=%b want 0/0", fwd_sig_from, hazard);
        end else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        issue(5'd8);
        issue(5'd9);
        head_valid = 1'b1;
        head_d     = 5'd8;
        head_s     = 5'd9;
        #1;
        n_checks++;
        if (fwd_sig_from !== 9'b000_100_010 || hazard !== 1'b1) begin
            $display("FAIL pre_async got sig=%b haz=%b want 000100010/1", fwd_sig_from, hazard);
        end else n_pass++;
        res_valid = 3'b011;
        res_val   = {N*VW{1'b1}};
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (fwd_sig_from !== 9'b0 || fwd_val_from !== '0 || hazard !== 1'b0) begin
            $display("FAIL async_reset got sig=%b haz=%b val_nonzero=%b want 0/0/0",
                     fwd_sig_from, hazard, |fwd_val_from);
        end else n_pass++;
        tick();
        rstn      = 1'b1;
        res_valid = 3'b000;
        tick();
        #1;
        n_checks++;
        if (fwd_sig_from !== 9'b0 || hazard !== 1'b0) begin
            $display("FAIL post_async got sig=%b haz=%b want 0/0", fwd_sig_from, hazard);
        end else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle_inputs();
        rstn = 1'b0;
        test_reset();
        test_single_issue();
        test_unready();
        test_priority();
        test_rip_nonwriter();
        test_stall_flush();
        test_retire();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/forward_source_tracker.md
Name: forward_source_tracker

Overview:
- Produces the per-stage forwarding signals and values that the decode stage consumes: fwd_sig_from[i] selects and fwd_val_from[i] values for each post-decode stage i.
- Tracks the destination register of every instruction issued out of decode as it moves through POST_DEC_LD stages, and captures results as stages produce them.
- Compares the tracked destinations against the d/s/t fields of the queue-head instruction and raises a hazard when a needed value is not yet available.
- Sits beside the decode stage; stage index 0 is the youngest stage, i.e. the stage immediately after decode.

Parameters:
- POST_DEC_LD, 3, number of post-decode stages tracked, one slot per stage.
- REG_W, 5, width of a register index.
- VAL_W, 64, width of a register value.
- RIP_IDX, 16, register index for RIP. A slot never produces a match on this index.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  an instruction leaves decode this cycle. Ignored while stall=1.
- issue_wr  in  1  the issued instruction writes a GPR.
- issue_dst  in  REG_W  destination of the issued instruction.
- stall  in  1  decode is stalled this cycle; a bubble enters slot 0.
- flush  in  1  pipeline flush.
- head_valid  in  1  the queue head is valid.
- head_d, head_s, head_t  in  REG_W each  operand fields of the queue head.
- res_valid  in  POST_DEC_LD  stage i produced its result this cycle.
- res_val  in  POST_DEC_LD*VAL_W  per-stage result values.
- fwd_sig_from  out  POST_DEC_LD*3  per stage, bits {d,s,t}: select this stage's value for that operand.
- fwd_val_from  out  POST_DEC_LD*VAL_W  per-stage forward value.
- hazard  out  1  the queue head needs a value that is not yet available.

Behaviour:
- Slot state, per slot: live, dst, have, val.
- Reset: all live=0, have=0, dst=0, val=0. Asynchronous on rstn low.
- Output values during reset:
  - fwd_sig_from is all 0.
  - fwd_val_from is all 0.
  - hazard is 0.
- Each rising edge when rstn=1 and flush=0:
  - Slot i+1 takes slot i. When res_valid[i]=1 and live[i]=1, the incoming slot i+1 has have=1 and val=res_val[i].
  - Slot 0 takes live = issue_valid & issue_wr & ~stall, dst = issue_dst, have = 0.
  - Slot POST_DEC_LD-1 retires; its result is then in the GPR file.
- Flush clears all live and have bits at the next edge. Flush has priority over issue and stall.
- avail[i] = have[i] | res_valid[i].
- cur[i] = have[i] ? val[i] : res_val[i]. Combinational from current state and inputs, zero-cycle latency.
- Raw match for operand x in {d,s,t}: m_x[i] = live[i] & (dst[i]==head_x) & (head_x != RIP_IDX) & head_valid.
- Priority: only the lowest matching index (youngest) asserts fwd_sig_from[i].x. All older matches for that operand are masked to 0.
- fwd_val_from[i] = cur[i] when any bit of fwd_sig_from[i] is set, else 0.
- hazard = OR over operands of (a youngest match exists and avail of that slot = 0). An older ready match never clears a hazard caused by a younger unready one.
- Duplicate destinations across slots are legal; the priority rule resolves them.
- An operand may match in a slot on the same edge that slot retires. The comparison uses pre-edge state, so the last stage still forwards during its final cycle.
- Reset mid-operation drops all in-flight slots immediately. Outputs go to 0 combinationally while rstn is low.

Test Plan:
- Reset, then a single issue: issue dst=3, wr=1; next cycle head_s=3, res_valid[0]=1, res_val[0]=0x55 → fwd_sig_from[0]={0,1,0}, fwd_val_from[0]=0x55, hazard=0.
- Unready value: same as the first case but res_valid[0]=0 → hazard=1 and fwd_sig_from[0].s=1. One edge later with res_valid[1]=1 and res_val[1]=0x77 → fwd_sig_from[1].s=1, fwd_val_from[1]=0x77, hazard=0.
- Priority: issue dst=5 in two consecutive cycles with values 0xA (older) and 0xB (younger), both captured; head_d=head_t=5 → only slot 0 is selected, fwd_val_from[0]=0xB, and slot 1 bits are 0.
- RIP and non-writers:
  - Issue dst=RIP_IDX with wr=1 and head_d=16 → no fwd_sig bits, hazard=0.
  - Issue wr=0 with dst=2 and head_s=2 → no match.
- Stall and flush:
  - Issue_valid=1 with stall=1 → slot 0 is not live.
  - With 3 live slots, assert flush → all fwd_sig_from=0 and hazard=0 next cycle, even if issue_valid=1 on the flush edge.
- Async reset: drop rstn mid-cycle with 2 live slots → outputs are 0 before the next clk edge. After release, no matches until a new issue.
